fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
REQ-007 imem_rvalid  input  1  read data for oldest granted request is present.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 redirect_valid  input  1  EX-stage branch/jump taken; squash and refetch.
REQ-010 redirect_pc  input  32  new fetch target, sampled with redirect_valid.
REQ-011 id_stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-012 id_valid  output  1  id_instr/id_pc/id_pc4 hold a valid fetched instruction.
REQ-013 id_instr, id_pc, id_pc4  output  32 each  instruction, its address, address+4.

Function
REQ-014 Fetch FSM has three states: REQ (imem_req=1), WAIT (one request outstanding), DROP (outstanding request squashed, response to be discarded).
REQ-015 At most one memory request shall be outstanding; imem_addr shall equal the PC register.
REQ-016 In REQ, imem_req shall assert only when FIFO occupancy is below 2; on imem_gnt the FSM moves to WAIT.
REQ-017 imem_req and imem_addr shall stay stable until imem_gnt, except when redirect_valid=1.
REQ-018 In WAIT on imem_rvalid: push {imem_rdata, pc, pc+4} into the 2-entry FIFO, PC <= PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), state -> REQ; earliest re-request is the same cycle's following edge (1-cycle bubble minimum).
REQ-019 In DROP on imem_rvalid: discard data, no push, state -> REQ.
REQ-020 id_valid = FIFO non-empty; id_* present the FIFO head; head pops when id_valid=1 and id_stall=0.
REQ-021 FIFO push and pop in the same cycle shall both occur; push into a full FIFO shall never happen (guaranteed by REQ-016).
REQ-022 redirect_valid has highest priority: FIFO flushed (id_valid=0 next cycle), PC <= {redirect_pc[31:2],2'b00}.
REQ-023 Redirect next state: DROP if a request is outstanding (WAIT, or REQ with imem_gnt in the same cycle); otherwise REQ.
REQ-024 Redirect in the same cycle as imem_rvalid in WAIT: response discarded, next state REQ.
REQ-025 Redirect while in DROP: PC updated, state remains DROP until imem_rvalid.
REQ-026 id_stall shall not affect redirect handling or FIFO flush.

Reset
REQ-027 While rst_n=0: PC=RESET_PC, state=REQ, FIFO empty, imem_req=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc4=0.
REQ-028 Reset asserted mid-request shall abandon the request; any later imem_rvalid for it is the memory's responsibility to suppress.
REQ-029 First imem_req shall assert in the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package riscv_pkg holds XLEN=32, NOP_INSTR=32'h0000_0013 and the fetch-state enum {F_REQ, F_WAIT, F_DROP}.
REQ-031 The 2-entry FIFO (push/pop/flush, count, 96-bit entry) shall be sub-module fetch_fifo.

Verification
REQ-032 Reset release, memory gnt same cycle, rvalid next cycle, id_stall=0 -> id_pc sequence 0,4,8,12 with matching id_instr; id_pc4 = id_pc+4.
REQ-033 id_stall=1 for 5 cycles after first instruction -> id_pc held at 0, FIFO fills to 2 (ids 0,4), imem_req drops; on release id_pc 0,4,8 without loss or duplication.
REQ-034 Redirect to 32'h0000_0103 while in WAIT for addr 8 -> response for 8 discarded, id_valid=0 next cycle, next imem_addr=32'h0000_0100, next id_pc=0x100.
REQ-035 Redirect to 0x200 in the same cycle as imem_rvalid for addr 4 -> addr-4 instruction never appears; next id_pc=0x200.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> id_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 rst_n pulsed low while in WAIT -> outputs at reset values immediately (asynchronous), fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end: data width,
// the canonical NOP encoding, fetch FSM states and the fetch queue entry.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched instructions between instruction memory and decode.
// Flush wins over push and pop so a squashed stream never leaks into decode.
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rdPtr_q;
  logic         wrPtr_q;
  logic [1:0]   count_q;
  logic         popEff;

  assign popEff  = pop_i && (count_q != 2'd0);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) wrPtr_q <= ~wrPtr_q;
      if (popEff) rdPtr_q <= ~rdPtr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, popEff};
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request at a time, responses
// queued for decode, redirects squash both the queue and any in-flight request.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPlus4;
  logic            accept;
  logic            push;
  logic            pop;
  logic            flush;
  logic [1:0]      fifoCount;
  fetch_entry_t    fifoHead;
  fetch_entry_t    fifoEntry;
  logic            unusedRedirectBits;

  assign unusedRedirectBits = ^redirect_pc[1:0];

  // Gating with rst_n keeps the request low throughout reset yet lets it rise
  // in the very first cycle after release.
  assign imem_req  = rst_n && (state_q == F_REQ) && (fifoCount < 2'd2);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;
  assign pcPlus4   = pc_q + 32'd4;
  assign fifoEntry = '{instr: imem_rdata, pc: pc_q, pc4: pcPlus4};

  assign id_valid  = (fifoCount != 2'd0);
  assign pop       = id_valid && !id_stall;
  assign id_instr  = id_valid ? fifoHead.instr : NOP_INSTR;
  assign id_pc     = id_valid ? fifoHead.pc    : '0;
  assign id_pc4    = id_valid ? fifoHead.pc4   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A redirect overrides everything; a still-pending response must be swallowed in DROP.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      case (state_q)
        F_REQ:   state_d = accept ? F_DROP : F_REQ;
        F_WAIT:  state_d = imem_rvalid ? F_REQ : F_DROP;
        F_DROP:  state_d = imem_rvalid ? F_REQ : F_DROP;
        default: state_d = F_REQ;
      endcase
    end else begin
      case (state_q)
        F_REQ: begin
          if (accept) state_d = F_WAIT;
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            pc_d    = pcPlus4;
            state_d = F_REQ;
          end
        end
        F_DROP: begin
          if (imem_rvalid) state_d = F_REQ;
        end
        default: state_d = F_REQ;
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .entry_i (fifoEntry),
    .head_o  (fifoHead),
    .count_o (fifoCount)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a tiny memory model answers requests, the
// stimulus queues expected fetch addresses, and a monitor checks every accepted instruction.
module tb_fetch_unit;

  logic        clk;
  logic        rstN        [2];
  logic        imemReq     [2];
  logic [31:0] imemAddr    [2];
  logic        imemGnt     [2];
  logic        imemRvalid  [2];
  logic [31:0] imemRdata   [2];
  logic        idValid     [2];
  logic [31:0] idInstr     [2];
  logic [31:0] idPc        [2];
  logic [31:0] idPc4       [2];
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        idStall;

  int          checks;
  int          errors;
  int          act;
  int          respDelay;
  int          pendCnt     [2];
  logic [31:0] pendAddr    [2];
  logic [31:0] expPc       [$];

  fetch_unit u_dut0 (
    .clk(clk), .rst_n(rstN[0]),
    .imem_req(imemReq[0]), .imem_addr(imemAddr[0]), .imem_gnt(imemGnt[0]),
    .imem_rvalid(imemRvalid[0]), .imem_rdata(imemRdata[0]),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc), .id_stall(idStall),
    .id_valid(idValid[0]), .id_instr(idInstr[0]), .id_pc(idPc[0]), .id_pc4(idPc4[0])
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .clk(clk), .rst_n(rstN[1]),
    .imem_req(imemReq[1]), .imem_addr(imemAddr[1]), .imem_gnt(imemGnt[1]),
    .imem_rvalid(imemRvalid[1]), .imem_rdata(imemRdata[1]),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc), .id_stall(idStall),
    .id_valid(idValid[1]), .id_instr(idInstr[1]), .id_pc(idPc[1]), .id_pc4(idPc4[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at each address, distinct from the NOP encoding.
  function automatic logic [31:0] mkInstr(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h0ACE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory: grants every request at once and answers 1+respDelay cycles later.
  initial begin
    for (int d = 0; d < 2; d++) begin
      pendCnt[d] = 0; pendAddr[d] = '0;
      imemGnt[d] = 1'b0; imemRvalid[d] = 1'b0; imemRdata[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rstN[d]) begin
          pendCnt[d] = 0; imemGnt[d] = 1'b0; imemRvalid[d] = 1'b0;
        end else begin
          imemRvalid[d] = 1'b0;
          if (pendCnt[d] != 0) begin
            pendCnt[d]--;
            if (pendCnt[d] == 0) begin
              imemRvalid[d] = 1'b1;
              imemRdata[d]  = mkInstr(pendAddr[d]);
            end
          end
          imemGnt[d] = imemReq[d];
          if (imemReq[d]) begin
            pendCnt[d]  = 1 + respDelay;
            pendAddr[d] = imemAddr[d];
          end
        end
      end
    end
  end

  // Monitor: every instruction decode accepts must be the next one expected.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rstN[act] && idValid[act] && !idStall && expPc.size() > 0) begin
        e = expPc.pop_front();
        checkOutput("id_pc",    idPc[act],    e);
        checkOutput("id_instr", idInstr[act], mkInstr(e));
        checkOutput("id_pc4",   idPc4[act],   e + 32'd4);
      end
    end
  end

  task automatic applyStimulus(input int d, input logic [31:0] resetPc);
    @(negedge clk);
    rstN[d] = 1'b1;
    act     = d;
    #1;
    checkOutput("first_req",  {31'd0, imemReq[d]}, 32'd1);
    checkOutput("first_addr", imemAddr[d], resetPc);
  endtask

  task automatic resetDut(input int d);
    @(negedge clk);
    rstN[d] = 1'b0;
    expPc.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (expPc.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput(name, expPc.size(), 0);
    expPc.delete();
  endtask

  task automatic waitReqAddr(input logic [31:0] a, input int budget);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      hit = imemReq[act] && (imemAddr[act] == a);
      n++;
    end
    checkOutput("req_seen", {31'd0, hit}, 32'd1);
  endtask

  task automatic waitReq(input int budget);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      hit = imemReq[act];
      n++;
    end
    checkOutput("req_resume", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; act = 0; respDelay = 0;
    rstN[0] = 1'b0; rstN[1] = 1'b0;
    redirectValid = 1'b0; redirectPc = '0; idStall = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_req",   {31'd0, imemReq[d]}, 32'd0);
      checkOutput("rst_valid", {31'd0, idValid[d]}, 32'd0);
      checkOutput("rst_instr", idInstr[d], 32'h0000_0013);
      checkOutput("rst_pc",    idPc[d],    32'd0);
      checkOutput("rst_pc4",   idPc4[d],   32'd0);
    end
    checkOutput("rst_addr0", imemAddr[0], 32'h0000_0000);
    checkOutput("rst_addr1", imemAddr[1], 32'hFFFF_FFF8);

    $display("[TB] streaming fetch");
    applyStimulus(0, 32'h0);
    expPc = '{32'h0, 32'h4, 32'h8, 32'hC};
    waitDrain("stream_drain", 60);

    $display("[TB] decode stall backpressure");
    resetDut(0);
    idStall = 1'b1;
    applyStimulus(0, 32'h0);
    expPc = '{32'h0, 32'h4, 32'h8};
    n = 0;
    while (!idValid[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checkOutput("stall_first_valid", {31'd0, idValid[0]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkOutput("stall_hold_pc", idPc[0], 32'h0);
    end
    checkOutput("stall_hold_instr", idInstr[0], mkInstr(32'h0));
    checkOutput("stall_full_req",   {31'd0, imemReq[0]}, 32'd0);
    @(negedge clk);
    idStall = 1'b0;
    waitDrain("stall_drain", 60);

    $display("[TB] redirect while waiting");
    resetDut(0);
    respDelay = 2;
    applyStimulus(0, 32'h0);
    expPc = '{32'h0, 32'h100, 32'h104};
    waitReqAddr(32'h8, 40);
    idStall = 1'b1;
    @(negedge clk);
    respDelay = 0;
    redirectValid = 1'b1; redirectPc = 32'h0000_0103;
    @(negedge clk);
    redirectValid = 1'b0; idStall = 1'b0;
    #1;
    checkOutput("redir_flush_valid", {31'd0, idValid[0]}, 32'd0);
    checkOutput("redir_drop_req",    {31'd0, imemReq[0]}, 32'd0);
    waitReq(20);
    #1;
    checkOutput("redir_addr", imemAddr[0], 32'h0000_0100);
    waitDrain("redir_drain", 60);

    $display("[TB] redirect with response");
    resetDut(0);
    applyStimulus(0, 32'h0);
    expPc = '{32'h0, 32'h200, 32'h204};
    waitReqAddr(32'h4, 40);
    @(negedge clk);
    redirectValid = 1'b1; redirectPc = 32'h0000_0200;
    @(negedge clk);
    redirectValid = 1'b0;
    #1;
    checkOutput("redir_rv_req",  {31'd0, imemReq[0]}, 32'd1);
    checkOutput("redir_rv_addr", imemAddr[0], 32'h0000_0200);
    waitDrain("redir_rv_drain", 60);

    $display("[TB] asynchronous reset while waiting");
    resetDut(0);
    respDelay = 3;
    applyStimulus(0, 32'h0);
    expPc = '{32'h0};
    waitReqAddr(32'h8, 40);
    idStall = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("areset_pre_valid", {31'd0, idValid[0]}, 32'd1);
    rstN[0] = 1'b0;
    #1;
    checkOutput("areset_valid", {31'd0, idValid[0]}, 32'd0);
    checkOutput("areset_req",   {31'd0, imemReq[0]}, 32'd0);
    checkOutput("areset_instr", idInstr[0], 32'h0000_0013);
    checkOutput("areset_pc",    idPc[0],    32'd0);
    checkOutput("areset_pc4",   idPc4[0],   32'd0);
    checkOutput("areset_addr",  imemAddr[0], 32'd0);
    checkOutput("areset_drained", expPc.size(), 0);
    expPc.delete();
    idStall = 1'b0; respDelay = 0;
    repeat (2) @(negedge clk);
    applyStimulus(0, 32'h0);
    expPc = '{32'h0, 32'h4, 32'h8};
    waitDrain("areset_drain", 60);

    $display("[TB] high reset PC wraps");
    resetDut(0);
    applyStimulus(1, 32'hFFFF_FFF8);
    expPc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    waitDrain("wrap_drain", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
